// File: rtl/memShare_config_pkg.sv
// rtl/memShare_config_pkg.sv - shared memShare rank configuration and remap controller types
//
// Purpose: rank geometry constants shared by the decoder, the IB-RAM rank and
// the IB-LUT remap load controller, plus the remap controller state encoding.
// Ports: none (package).

package memShare_config_pkg;

  localparam int SHARE_GROUP_SIZE  = 4;   // VNs per share-group rank
  localparam int QUAN_SIZE         = 3;   // c2v/v2c message width
  localparam int GP2_COL_SEL_WIDTH = 2;   // per-VN column-select field width
  localparam int Q4_BI4_WDATA_SIZE = 8;   // per-VN remap write-word width
  localparam int GP2_VN_LOAD_CYCLE = 16;  // write beats per full IB-LUT load

  localparam int REMAP_BEAT_W = $clog2(GP2_VN_LOAD_CYCLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } remap_state_e;

endpackage

// File: rtl/memshare_remap_addr_gen.sv
// rtl/memshare_remap_addr_gen.sv - remap load beat counter and rank write-address generator
//
// Purpose: counts accepted load beats and splits the beat index into the
// rank write address {colSel field, c2v field}, replicated to every VN.
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   clr_i          clear the beat counter (start of a load)
//   inc_i          advance to the next beat
//   last_o         current beat is the final beat of a load
//   col_sel_vec_o  colSel field of the current beat address, all VNs
//   c2v_vec_o      c2v field of the current beat address, all VNs

module memshare_remap_addr_gen #(
  parameter int SHARE_GROUP_SIZE = 4,
  parameter int QUAN_SIZE        = 3,
  parameter int COL_SEL_W        = 2,
  parameter int LOAD_CYCLES      = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clr_i,
  input  logic                                  inc_i,
  output logic                                  last_o,
  output logic [COL_SEL_W*SHARE_GROUP_SIZE-1:0] col_sel_vec_o,
  output logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] c2v_vec_o
);

  localparam int BEAT_W = $clog2(LOAD_CYCLES);
  localparam int ADDR_W = COL_SEL_W + QUAN_SIZE;

  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]    beat_addr;
  logic [COL_SEL_W-1:0] col_sel_field;
  logic [QUAN_SIZE-1:0] c2v_field;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clr_i) begin
      beat_cnt_d = '0;
    end else if (inc_i) begin
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign last_o = (beat_cnt_q == BEAT_W'(LOAD_CYCLES - 1));

  // Beat index zero-extended to the full address; low bits select the c2v
  // row, any remaining high bits select the column.
  assign beat_addr     = ADDR_W'(beat_cnt_q);
  assign col_sel_field = beat_addr[ADDR_W-1:QUAN_SIZE];
  assign c2v_field     = beat_addr[QUAN_SIZE-1:0];

  assign col_sel_vec_o = {SHARE_GROUP_SIZE{col_sel_field}};
  assign c2v_vec_o     = {SHARE_GROUP_SIZE{c2v_field}};

endmodule

// File: rtl/memshare_ibram_remap_ctrl.sv
// rtl/memshare_ibram_remap_ctrl.sv - IB-LUT load sequencer and rank address arbiter
//
// Purpose: streams LOAD_CYCLES beats of new IB-LUT contents into every VN
// IB-RAM of one share-group rank, owning the rank address/remap-enable nets
// while loading and handing them back to the decoder when idle.
// Ports:
//   sys_clk           clock
//   rst               synchronous active-high reset
//   start_i           one-cycle pulse, begin a load (ignored unless idle)
//   remap_data_i      LUT words for all VNs of one beat
//   remap_valid_i     remap_data_i valid
//   remap_ready_o     beat accepted when valid & ready
//   dec_colSel_i      decoder column selects
//   dec_c2v_i         decoder c2v messages
//   dec_gnt_o         decoder owns the rank address nets
//   rank_colSel_o     registered rank column selects
//   rank_c2v_o        registered rank c2v messages
//   rank_remapData_o  registered rank remap write data
//   rank_nRemap_en_o  registered rank remap write enable, active low
//   busy_o            load in progress
//   done_o            one-cycle pulse, load complete

module memshare_ibram_remap_ctrl
  import memShare_config_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE = memShare_config_pkg::SHARE_GROUP_SIZE,
  parameter int QUAN_SIZE        = memShare_config_pkg::QUAN_SIZE,
  parameter int COL_SEL_W        = memShare_config_pkg::GP2_COL_SEL_WIDTH,
  parameter int WDATA_W          = memShare_config_pkg::Q4_BI4_WDATA_SIZE,
  parameter int LOAD_CYCLES      = memShare_config_pkg::GP2_VN_LOAD_CYCLE
) (
  input  logic                                  sys_clk,
  input  logic                                  rst,
  input  logic                                  start_i,
  input  logic [WDATA_W*SHARE_GROUP_SIZE-1:0]   remap_data_i,
  input  logic                                  remap_valid_i,
  output logic                                  remap_ready_o,
  input  logic [COL_SEL_W*SHARE_GROUP_SIZE-1:0] dec_colSel_i,
  input  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] dec_c2v_i,
  output logic                                  dec_gnt_o,
  output logic [COL_SEL_W*SHARE_GROUP_SIZE-1:0] rank_colSel_o,
  output logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] rank_c2v_o,
  output logic [WDATA_W*SHARE_GROUP_SIZE-1:0]   rank_remapData_o,
  output logic                                  rank_nRemap_en_o,
  output logic                                  busy_o,
  output logic                                  done_o
);

  remap_state_e state_q, state_d;

  logic                                  beat_accept;
  logic                                  beat_last;
  logic                                  cnt_clr;
  logic [COL_SEL_W*SHARE_GROUP_SIZE-1:0] gen_col_sel_vec;
  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] gen_c2v_vec;

  logic [COL_SEL_W*SHARE_GROUP_SIZE-1:0] col_sel_q, col_sel_d;
  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0] c2v_q, c2v_d;
  logic [WDATA_W*SHARE_GROUP_SIZE-1:0]   wdata_q, wdata_d;
  logic                                  n_remap_en_q, n_remap_en_d;

  assign remap_ready_o = (state_q == FILL);
  assign beat_accept   = remap_valid_i & remap_ready_o;
  assign cnt_clr       = (state_q == IDLE) & start_i;

  // The counter parks on the last beat instead of wrapping; it only returns
  // to zero when the next load starts.
  memshare_remap_addr_gen #(
    .SHARE_GROUP_SIZE (SHARE_GROUP_SIZE),
    .QUAN_SIZE        (QUAN_SIZE),
    .COL_SEL_W        (COL_SEL_W),
    .LOAD_CYCLES      (LOAD_CYCLES)
  ) u_addr_gen (
    .clk_i         (sys_clk),
    .rst_i         (rst),
    .clr_i         (cnt_clr),
    .inc_i         (beat_accept & ~beat_last),
    .last_o        (beat_last),
    .col_sel_vec_o (gen_col_sel_vec),
    .c2v_vec_o     (gen_c2v_vec)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = FILL;
      FILL:    if (beat_accept && beat_last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rank nets: decoder passthrough while idle; during a load the address
  // only moves on an accepted beat so a stall leaves it parked.
  always_comb begin
    col_sel_d    = col_sel_q;
    c2v_d        = c2v_q;
    wdata_d      = wdata_q;
    n_remap_en_d = ~beat_accept;
    if (state_q == IDLE) begin
      col_sel_d = dec_colSel_i;
      c2v_d     = dec_c2v_i;
    end else if (beat_accept) begin
      col_sel_d = gen_col_sel_vec;
      c2v_d     = gen_c2v_vec;
      wdata_d   = remap_data_i;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_sel_q    <= '0;
      c2v_q        <= '0;
      wdata_q      <= '0;
      n_remap_en_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      col_sel_q    <= col_sel_d;
      c2v_q        <= c2v_d;
      wdata_q      <= wdata_d;
      n_remap_en_q <= n_remap_en_d;
    end
  end

  assign rank_colSel_o    = col_sel_q;
  assign rank_c2v_o       = c2v_q;
  assign rank_remapData_o = wdata_q;
  assign rank_nRemap_en_o = n_remap_en_q;

  assign dec_gnt_o = (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);

endmodule

// File: tb/tb_memshare_ibram_remap_ctrl.sv
// tb/tb_memshare_ibram_remap_ctrl.sv - directed self-checking bench for the IB-LUT remap controller

module tb_memshare_ibram_remap_ctrl;
  import memShare_config_pkg::*;

  localparam int SGS = SHARE_GROUP_SIZE;
  localparam int QW  = QUAN_SIZE;
  localparam int CW  = GP2_COL_SEL_WIDTH;
  localparam int DW  = Q4_BI4_WDATA_SIZE;
  localparam int LC  = GP2_VN_LOAD_CYCLE;

  logic                sys_clk;
  logic                rst;
  logic                start_i;
  logic [DW*SGS-1:0]   remap_data_i;
  logic                remap_valid_i;
  logic                remap_ready_o;
  logic [CW*SGS-1:0]   dec_colSel_i;
  logic [QW*SGS-1:0]   dec_c2v_i;
  logic                dec_gnt_o;
  logic [CW*SGS-1:0]   rank_colSel_o;
  logic [QW*SGS-1:0]   rank_c2v_o;
  logic [DW*SGS-1:0]   rank_remapData_o;
  logic                rank_nRemap_en_o;
  logic                busy_o;
  logic                done_o;

  memshare_ibram_remap_ctrl dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .start_i          (start_i),
    .remap_data_i     (remap_data_i),
    .remap_valid_i    (remap_valid_i),
    .remap_ready_o    (remap_ready_o),
    .dec_colSel_i     (dec_colSel_i),
    .dec_c2v_i        (dec_c2v_i),
    .dec_gnt_o        (dec_gnt_o),
    .rank_colSel_o    (rank_colSel_o),
    .rank_c2v_o       (rank_c2v_o),
    .rank_remapData_o (rank_remapData_o),
    .rank_nRemap_en_o (rank_nRemap_en_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int                wr_cyc[$];
  logic [CW*SGS-1:0] wr_col[$];
  logic [QW*SGS-1:0] wr_c2v[$];
  logic [DW*SGS-1:0] wr_data[$];
  int                acc_cyc[$];
  int                done_cnt = 0;
  int                done_cyc = -1;

  always @(negedge sys_clk) begin
    if (rank_nRemap_en_o === 1'b0) begin
      wr_cyc.push_back(cyc);
      wr_col.push_back(rank_colSel_o);
      wr_c2v.push_back(rank_c2v_o);
      wr_data.push_back(rank_remapData_o);
    end
    if (done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [DW*SGS-1:0] beat_data(input int k, input int seed);
    logic [DW*SGS-1:0] d;
    for (int v = 0; v < SGS; v++) d[v*DW +: DW] = DW'(k * 13 + v * 37 + seed);
    return d;
  endfunction

  function automatic logic [QW*SGS-1:0] exp_c2v(input int k);
    logic [QW*SGS-1:0] r;
    for (int v = 0; v < SGS; v++) r[v*QW +: QW] = QW'(k % (1 << QW));
    return r;
  endfunction

  function automatic logic [CW*SGS-1:0] exp_col(input int k);
    logic [CW*SGS-1:0] r;
    for (int v = 0; v < SGS; v++) r[v*CW +: CW] = CW'(k >> QW);
    return r;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_cyc.delete();
    wr_col.delete();
    wr_c2v.delete();
    wr_data.delete();
    acc_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  // Pulses start then offers beats until all are accepted (or rst_beat is hit).
  task automatic drive_load(input int stall, input int start_beat, input int rst_beat,
                            input int rand_dec, input int seed);
    int   k;
    int   idx;
    logic rdy;
    clear_logs();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    k = 0;
    idx = 0;
    while (k < LC && idx < 200) begin
      remap_valid_i = (stall == 0) || (idx % 3 == 0);
      remap_data_i  = beat_data(k, seed);
      start_i       = (k == start_beat);
      if (rand_dec != 0) begin
        dec_c2v_i    = (QW*SGS)'($urandom);
        dec_colSel_i = (CW*SGS)'($urandom);
      end
      if (k == rst_beat) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        remap_valid_i = 1'b0;
        start_i = 1'b0;
        return;
      end
      rdy = remap_ready_o;
      if (remap_valid_i && rdy) acc_cyc.push_back(cyc);
      tick();
      if (remap_valid_i && rdy) k++;
      idx++;
    end
    remap_valid_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (k != LC) begin
      errors++;
      $display("FAIL load_progress: accepted %0d beats, required %0d", k, LC);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy_o !== 1'b0; i++) tick();
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy_o=%b after bound, required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (rank_nRemap_en_o !== 1'b1) begin errors++; $display("FAIL reset_nremap: got %b want 1", rank_nRemap_en_o); end
    checks++; if (dec_gnt_o !== 1'b1) begin errors++; $display("FAIL reset_gnt: got %b want 1", dec_gnt_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++; if (remap_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", remap_ready_o); end
    checks++; if (rank_remapData_o !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", rank_remapData_o); end
  endtask

  task automatic test_full_load();
    drive_load(0, -1, -1, 0, 8'h11);
    wait_idle();
    checks++;
    if (wr_cyc.size() != LC) begin errors++; $display("FAIL full_wr_count: got %0d want %0d", wr_cyc.size(), LC); end
    for (int i = 0; i < LC && i < wr_cyc.size() && i < acc_cyc.size(); i++) begin
      checks++; if (wr_c2v[i] !== exp_c2v(i)) begin errors++; $display("FAIL full_c2v[%0d]: got %h want %h", i, wr_c2v[i], exp_c2v(i)); end
      checks++; if (wr_col[i] !== exp_col(i)) begin errors++; $display("FAIL full_col[%0d]: got %h want %h", i, wr_col[i], exp_col(i)); end
      checks++; if (wr_data[i] !== beat_data(i, 8'h11)) begin errors++; $display("FAIL full_data[%0d]: got %h want %h", i, wr_data[i], beat_data(i, 8'h11)); end
      checks++; if (wr_cyc[i] != acc_cyc[i] + 1) begin errors++; $display("FAIL full_wr_latency[%0d]: write cycle %0d want %0d", i, wr_cyc[i], acc_cyc[i] + 1); end
      checks++; if (wr_cyc[i] != wr_cyc[0] + i) begin errors++; $display("FAIL full_consecutive[%0d]: cycle %0d want %0d", i, wr_cyc[i], wr_cyc[0] + i); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
    if (acc_cyc.size() == LC) begin
      checks++;
      if (done_cyc != acc_cyc[LC-1] + 2) begin errors++; $display("FAIL full_done_latency: done at %0d want %0d", done_cyc, acc_cyc[LC-1] + 2); end
    end
    checks++; if (dec_gnt_o !== 1'b1) begin errors++; $display("FAIL full_gnt_after: got %b want 1", dec_gnt_o); end
  endtask

  task automatic test_stalls();
    drive_load(1, -1, -1, 0, 8'h5A);
    wait_idle();
    checks++;
    if (wr_cyc.size() != LC) begin errors++; $display("FAIL stall_wr_count: got %0d want %0d", wr_cyc.size(), LC); end
    for (int i = 0; i < LC && i < wr_cyc.size() && i < acc_cyc.size(); i++) begin
      checks++; if (wr_c2v[i] !== exp_c2v(i) || wr_col[i] !== exp_col(i)) begin errors++; $display("FAIL stall_addr[%0d]: got col %h c2v %h want col %h c2v %h", i, wr_col[i], wr_c2v[i], exp_col(i), exp_c2v(i)); end
      checks++; if (wr_data[i] !== beat_data(i, 8'h5A)) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, wr_data[i], beat_data(i, 8'h5A)); end
      checks++; if (wr_cyc[i] != acc_cyc[i] + 1) begin errors++; $display("FAIL stall_wr_cycle[%0d]: write cycle %0d want %0d", i, wr_cyc[i], acc_cyc[i] + 1); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_arbitration();
    logic [QW*SGS-1:0] c2v5;
    logic [CW*SGS-1:0] col2;
    for (int v = 0; v < SGS; v++) begin
      c2v5[v*QW +: QW] = QW'(5);
      col2[v*CW +: CW] = CW'(2);
    end
    dec_c2v_i    = '0;
    dec_colSel_i = '0;
    tick();
    dec_c2v_i    = c2v5;
    dec_colSel_i = col2;
    #1;
    checks++; if (rank_c2v_o !== '0) begin errors++; $display("FAIL arb_latency: rank_c2v %h changed before clock, want 0", rank_c2v_o); end
    tick();
    checks++; if (rank_c2v_o !== c2v5) begin errors++; $display("FAIL arb_c2v_idle: got %h want %h", rank_c2v_o, c2v5); end
    checks++; if (rank_colSel_o !== col2) begin errors++; $display("FAIL arb_col_idle: got %h want %h", rank_colSel_o, col2); end
    // Data offered while idle must not be taken.
    remap_valid_i = 1'b1;
    remap_data_i  = beat_data(3, 8'h77);
    tick();
    checks++; if (remap_ready_o !== 1'b0 || rank_nRemap_en_o !== 1'b1) begin errors++; $display("FAIL arb_valid_idle: ready %b nremap %b want 0 1", remap_ready_o, rank_nRemap_en_o); end
    remap_valid_i = 1'b0;
    drive_load(0, -1, -1, 1, 8'h33);
    wait_idle();
    checks++;
    if (wr_cyc.size() != LC) begin errors++; $display("FAIL arb_wr_count: got %0d want %0d", wr_cyc.size(), LC); end
    for (int i = 0; i < LC && i < wr_cyc.size(); i++) begin
      checks++; if (wr_c2v[i] !== exp_c2v(i) || wr_col[i] !== exp_col(i)) begin errors++; $display("FAIL arb_load_addr[%0d]: got col %h c2v %h want col %h c2v %h", i, wr_col[i], wr_c2v[i], exp_col(i), exp_c2v(i)); end
    end
  endtask

  task automatic test_start_ignored();
    int found;
    drive_load(0, 7, -1, 0, 8'h42);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (done_o === 1'b1) found = 1;
      else tick();
    end
    checks++; if (found == 0) begin errors++; $display("FAIL start_wait_done: done_o not seen, want 1"); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL start_with_done: busy %b want 0", busy_o); end
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL start_no_queue: busy %b want 0", busy_o); end
    checks++; if (wr_cyc.size() != LC) begin errors++; $display("FAIL start_wr_count: got %0d want %0d", wr_cyc.size(), LC); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL start_done_count: got %0d want 1", done_cnt); end
    for (int i = 0; i < LC && i < wr_cyc.size(); i++) begin
      checks++; if (wr_c2v[i] !== exp_c2v(i) || wr_col[i] !== exp_col(i)) begin errors++; $display("FAIL start_addr[%0d]: got col %h c2v %h want col %h c2v %h", i, wr_col[i], wr_c2v[i], exp_col(i), exp_c2v(i)); end
    end
  endtask

  task automatic test_reset_mid_load();
    drive_load(0, -1, 9, 0, 8'h21);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
    checks++; if (dec_gnt_o !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt: got %b want 1", dec_gnt_o); end
    checks++; if (rank_nRemap_en_o !== 1'b1) begin errors++; $display("FAIL rst_mid_nremap: got %b want 1", rank_nRemap_en_o); end
    checks++; if (rank_remapData_o !== '0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", rank_remapData_o); end
    checks++; if (remap_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", remap_ready_o); end
    tick();
    checks++; if (wr_cyc.size() != 9) begin errors++; $display("FAIL rst_mid_wr_count: got %0d want 9", wr_cyc.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rst_mid_done: got %0d want 0", done_cnt); end
    drive_load(0, -1, -1, 0, 8'h99);
    wait_idle();
    checks++; if (wr_cyc.size() != LC) begin errors++; $display("FAIL rst_restart_count: got %0d want %0d", wr_cyc.size(), LC); end
    if (wr_cyc.size() > 0) begin
      checks++;
      if (wr_c2v[0] !== exp_c2v(0) || wr_col[0] !== exp_col(0)) begin errors++; $display("FAIL rst_restart_addr0: got col %h c2v %h want 0 0", wr_col[0], wr_c2v[0]); end
      checks++;
      if (wr_data[0] !== beat_data(0, 8'h99)) begin errors++; $display("FAIL rst_restart_data0: got %h want %h", wr_data[0], beat_data(0, 8'h99)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rst_restart_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    rst           = 1'b1;
    start_i       = 1'b0;
    remap_data_i  = '0;
    remap_valid_i = 1'b0;
    dec_colSel_i  = '0;
    dec_c2v_i     = '0;
    test_reset();
    test_full_load();
    test_stalls();
    test_arbitration();
    test_start_ignored();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
